dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and the CPU memory stage:
// default address/data widths and the arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package dmem_pkg;

  // Word-address width (1024 words) and data word width.
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // Arbiter sequencing: wait for a request, drive the memory for one cycle,
  // then return the acknowledge (and read data) to the winning port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter.
//   req   : request, held high by the requester until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   ack   : one-cycle completion pulse from the arbiter
//   rdata : read data, valid while ack is high for reads
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick. Purely combinational.
//   req_i   : [0] port 0 request, [1] port 1 request
//   last_i  : port served most recently (0 or 1)
//   grant_o : one-hot grant, all zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; on a tie the port that was not served
  // last gets the grant.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between two requesters (port 0 = CPU
// load/store, port 1 = debug/DMA). Each transaction takes IDLE -> ACCESS ->
// RESP, so at most one transaction completes every three cycles.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   port0_io     : requester port 0 (slave modport)
//   port1_io     : requester port 1 (slave modport)
//   mem_addr_o   : memory word address
//   mem_din_o    : memory write data
//   mem_wr_rd_o  : memory direction, 1 = write, 0 = read
//   mem_dout_i   : memory read data
//   busy_o       : high whenever the FSM is not in IDLE
// The memory itself lives outside this block.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     port0_io,
  dmem_arbiter_if.slave     port1_io,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_wr_rd_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              busy_o
);

  import dmem_pkg::state_e;
  import dmem_pkg::IDLE;
  import dmem_pkg::ACCESS;
  import dmem_pkg::RESP;

  state_e            state_q;
  logic              last_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              wr_rd_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        grant_d;
  logic              sel_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;

  rr_arb2 u_rr_arb2 (
    .req_i   ({port1_io.req, port0_io.req}),
    .last_i  (last_q),
    .grant_o (grant_d)
  );

  // Steer the winning port's request fields toward the latch registers.
  always_comb begin
    sel_d  = grant_d[1];
    we_d   = sel_d ? port1_io.we    : port0_io.we;
    addr_d = sel_d ? port1_io.addr  : port0_io.addr;
    din_d  = sel_d ? port1_io.wdata : port0_io.wdata;
  end

  // Arbiter FSM. Request fields are captured at the grant edge so the
  // requester may change or drop them afterwards. The memory direction
  // register doubles as the latched write flag while in ACCESS, and it is
  // cleared by reset so an aborted write never reaches the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      wr_rd_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant_d) begin
            state_q <= ACCESS;
            sel_q   <= sel_d;
            last_q  <= sel_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_rd_q <= we_d;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          wr_rd_q <= 1'b0;
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          if (!wr_rd_q) begin
            if (sel_q) begin
              rdata1_q <= mem_dout_i;
            end else begin
              rdata0_q <= mem_dout_i;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o     = addr_q;
  assign mem_din_o      = din_q;
  assign mem_wr_rd_o    = wr_rd_q;
  assign busy_o         = (state_q != IDLE);

  assign port0_io.ack   = ack0_q;
  assign port0_io.rdata = rdata0_q;
  assign port1_io.ack   = ack1_q;
  assign port1_io.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives two requester ports against dmem_arbiter with a behavioural data
// memory attached. Expected acknowledges, write pulses and busy cycles are
// predicted from the arbitration rules and compared by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wr_rd;
  logic [DW-1:0] mem_dout;
  logic          busy;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t expq[$];
  wr_t  wq[$];
  bit   busy_sched[int];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   last_served = 1'b1;

  dmem_arbiter_if p0 ();
  dmem_arbiter_if p1 ();

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port0_io    (p0),
    .port1_io    (p1),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .mem_wr_rd_o (mem_wr_rd),
    .mem_dout_i  (mem_dout),
    .busy_o      (busy)
  );

  // Free-running clock and a cycle counter used to time-stamp predictions.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initVal(input int i);
    return 32'h1000_0000 + i * 7 + 3;
  endfunction

  // Behavioural data memory: combinational read, write on the clock edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = initVal(i);
    forever begin
      @(posedge clk);
      if (mem_wr_rd) mem[mem_addr] <= mem_din;
    end
  end

  assign mem_dout = mem[mem_addr];

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drivePort(input bit port, input bit on, input op_t op);
    if (port == 1'b0) begin
      p0.req   = on;
      p0.we    = on ? op.we : 1'($urandom_range(0, 1));
      p0.addr  = on ? op.addr : AW'($urandom);
      p0.wdata = on ? op.data : $urandom;
    end else begin
      p1.req   = on;
      p1.we    = on ? op.we : 1'($urandom_range(0, 1));
      p1.addr  = on ? op.addr : AW'($urandom);
      p1.wdata = on ? op.data : $urandom;
    end
  endtask

  task automatic idlePorts();
    op_t none;
    none = '{we: 1'b0, addr: '0, data: '0};
    drivePort(1'b0, 1'b0, none);
    drivePort(1'b1, 1'b0, none);
  endtask

  // Predict one grant: pick the winner, record the ack/write/busy it causes,
  // and update the reference memory.
  task automatic predictGrant(input bit win, input op_t op, input int g);
    exp_t e;
    e.port = win;
    e.we   = op.we;
    e.addr = op.addr;
    e.data = op.we ? op.data : ref_mem[op.addr];
    e.cyc  = g + 1;
    expq.push_back(e);
    if (op.we) begin
      ref_mem[op.addr] = op.data;
      wq.push_back('{addr: op.addr, data: op.data, cyc: g});
    end
    busy_sched[g]     = 1'b1;
    busy_sched[g + 1] = 1'b1;
    last_served = win;
  endtask

  // Present the queued operations of both ports, each port keeping its
  // request high until acknowledged and then moving to its next operation.
  // Both ports are pending from the first cycle, so grants fall every three
  // cycles and only the round-robin rule decides the order.
  task automatic applyStimulus();
    int  c, g, i0, i1, guard, budget;
    bit  a0, a1, win;
    c = 0;
    @(posedge clk);
    #1;
    c  = cyc;
    g  = c + 1;
    i0 = 0;
    i1 = 0;
    while (i0 < pend0.size() || i1 < pend1.size()) begin
      if (i0 < pend0.size() && i1 < pend1.size()) win = ~last_served;
      else win = (i1 < pend1.size());
      if (win) begin
        predictGrant(1'b1, pend1[i1], g);
        i1++;
      end else begin
        predictGrant(1'b0, pend0[i0], g);
        i0++;
      end
      g += 3;
    end
    if (pend0.size() != 0) drivePort(1'b0, 1'b1, pend0[0]);
    if (pend1.size() != 0) drivePort(1'b1, 1'b1, pend1[0]);
    guard  = 0;
    budget = 3 * (pend0.size() + pend1.size()) + 8;
    while ((pend0.size() != 0 || pend1.size() != 0) && guard < budget) begin
      @(negedge clk);
      a0 = p0.ack;
      a1 = p1.ack;
      @(posedge clk);
      #1;
      if (a0 && pend0.size() != 0) begin
        pend0.delete(0);
        if (pend0.size() != 0) drivePort(1'b0, 1'b1, pend0[0]);
        else drivePort(1'b0, 1'b0, '{we: 1'b0, addr: '0, data: '0});
      end
      if (a1 && pend1.size() != 0) begin
        pend1.delete(0);
        if (pend1.size() != 0) drivePort(1'b1, 1'b1, pend1[0]);
        else drivePort(1'b1, 1'b0, '{we: 1'b0, addr: '0, data: '0});
      end
      guard++;
    end
    if (pend0.size() != 0 || pend1.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL ack timeout: pending=%0d required=0", pend0.size() + pend1.size());
      pend0.delete();
      pend1.delete();
      expq.delete();
      wq.delete();
      idlePorts();
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ack0", p0.ack, 0);
    checkOutput("reset ack1", p1.ack, 0);
    checkOutput("reset mem_wr_rd", mem_wr_rd, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_din", mem_din, 0);
    checkOutput("reset rdata0", p0.rdata, 0);
    checkOutput("reset rdata1", p1.rdata, 0);
  endtask

  // Port 1 writes 50 to word 4, then right after the grant changes its
  // address to 7 and drops the request; the latched fields must be used.
  task automatic lateChangeTest();
    int  c, n;
    op_t op;
    @(posedge clk);
    #1;
    c  = cyc;
    op = '{we: 1'b1, addr: AW'(4), data: 32'd50};
    predictGrant(1'b1, op, c + 1);
    drivePort(1'b1, 1'b1, op);
    @(posedge clk);
    #1;
    p1.req   = 1'b0;
    p1.addr  = AW'(7);
    p1.wdata = 32'hDEAD_BEEF;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(p1.ack);
    end
    checkOutput("ack1 pulse count", n, 1);
  endtask

  // Reset asserted in the ACCESS cycle of a write of 30 to word 1.
  task automatic abortTest();
    @(posedge clk);
    #1;
    drivePort(1'b0, 1'b1, '{we: 1'b1, addr: AW'(1), data: 32'd30});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    idlePorts();
    last_served = 1'b1;
    checkResetState();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  // Monitor: compares every DUT output event against the predictions.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      wr_t  w;
      checkOutput("busy", busy, busy_sched.exists(cyc));
      checkOutput("ack overlap", p0.ack & p1.ack, 0);
      if (p0.ack || p1.ack) begin
        checkOutput("ack expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          checkOutput("ack port", p1.ack, e.port);
          checkOutput("ack cycle", cyc, e.cyc);
          if (!e.we) checkOutput("rdata", e.port ? p1.rdata : p0.rdata, e.data);
        end
      end
      if (mem_wr_rd) begin
        checkOutput("write expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          checkOutput("write addr", mem_addr, w.addr);
          checkOutput("write data", mem_din, w.data);
          checkOutput("write cycle", cyc, w.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int n, k0, k1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = initVal(i);
    idlePorts();
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] simultaneous requests, four transactions");
    pend0.push_back('{we: 1'b0, addr: AW'(10), data: '0});
    pend0.push_back('{we: 1'b1, addr: AW'(11), data: 32'hAAAA});
    pend1.push_back('{we: 1'b0, addr: AW'(12), data: '0});
    pend1.push_back('{we: 1'b0, addr: AW'(11), data: '0});
    applyStimulus();

    $display("[TB] port 0 write then read of word 0");
    pend0.push_back('{we: 1'b1, addr: AW'(0), data: 32'd20});
    applyStimulus();
    pend0.push_back('{we: 1'b0, addr: AW'(0), data: '0});
    applyStimulus();

    $display("[TB] port 1 fields change after grant");
    lateChangeTest();
    pend0.push_back('{we: 1'b0, addr: AW'(4), data: '0});
    pend0.push_back('{we: 1'b0, addr: AW'(7), data: '0});
    applyStimulus();

    $display("[TB] reset during write access");
    abortTest();
    pend0.push_back('{we: 1'b0, addr: AW'(1), data: '0});
    pend1.push_back('{we: 1'b0, addr: AW'(5), data: '0});
    applyStimulus();

    $display("[TB] back-to-back reads");
    pend0.push_back('{we: 1'b1, addr: AW'(1), data: 32'd30});
    pend0.push_back('{we: 1'b1, addr: AW'(2), data: 32'd40});
    applyStimulus();
    pend0.push_back('{we: 1'b0, addr: AW'(1), data: '0});
    pend0.push_back('{we: 1'b0, addr: AW'(2), data: '0});
    pend0.push_back('{we: 1'b0, addr: AW'(3), data: '0});
    applyStimulus();

    $display("[TB] random mixed traffic");
    n = 0;
    while (n < 60) begin
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      if (k0 + k1 == 0) k0 = 1;
      for (int i = 0; i < k0; i++)
        pend0.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom), data: $urandom});
      for (int i = 0; i < k1; i++)
        pend1.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom), data: $urandom});
      applyStimulus();
      n += k0 + k1;
    end

    $display("[TB] random read-only traffic");
    n = 0;
    while (n < 1000) begin
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      if (k0 + k1 == 0) k1 = 1;
      for (int i = 0; i < k0; i++)
        pend0.push_back('{we: 1'b0, addr: AW'($urandom), data: '0});
      for (int i = 0; i < k1; i++)
        pend1.push_back('{we: 1'b0, addr: AW'($urandom), data: '0});
      applyStimulus();
      n += k0 + k1;
    end

    repeat (5) @(posedge clk);
    checkOutput("leftover acks", expq.size(), 0);
    checkOutput("leftover writes", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
